adc_spi_poller: RTL and testbench



---
 rtl/adc_spi_poller.sv | 163 ++++++++++++++++
 tb/tb_adc_spi_poller.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_poller.sv
// Multi-channel SPI ADC poller: shared cs/sclk, NUM_CH parallel sdin lines,
// one-shot or continuous acquisition with optional 2^AVG_LOG2 averaging.
//
// state          | meaning
// S_IDLE         | cs high, waiting for cont or start
// S_HOLD         | cs high, gap between continuous transactions
// S_FRONT_PORCH  | cs low, before the first sclk low phase
// S_SHIFTING     | cs low, DATA_BITS sclk periods, sdin sampled each bit
// S_BACK_PORCH   | cs low, after the last bit
module adc_spi_poller #(
    parameter int NUM_CH                      = 2,
    parameter int DATA_BITS                   = 16,
    parameter int CLOCKS_PER_BIT              = 20,
    parameter int CLOCKS_BEFORE_DATA          = 60,
    parameter int CLOCKS_AFTER_DATA           = 500,
    parameter int CLOCKS_BETWEEN_TRANSACTIONS = 400,
    parameter int AVG_LOG2                    = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cont,
    input  logic                          start,
    input  logic [NUM_CH-1:0]             sdin,
    output logic                          cs,
    output logic                          sclk,
    output logic [NUM_CH*DATA_BITS-1:0]   dout,
    output logic                          drdy
);
    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int HALF = CLOCKS_PER_BIT / 2;
    localparam int CMAX = imax(imax(CLOCKS_PER_BIT, CLOCKS_BEFORE_DATA),
                               imax(CLOCKS_AFTER_DATA, CLOCKS_BETWEEN_TRANSACTIONS));
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(DATA_BITS + 1);
    localparam int AW   = DATA_BITS + AVG_LOG2;
    localparam int VW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [VW-1:0] CONV_LAST = VW'((1 << AVG_LOG2) - 1);

    // state[2] is the inverted chip select, so cs comes straight off a flop.
    typedef enum logic [2:0] {
        S_IDLE        = 3'b000,
        S_HOLD        = 3'b001,
        S_FRONT_PORCH = 3'b100,
        S_SHIFTING    = 3'b101,
        S_BACK_PORCH  = 3'b110
    } state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [BW-1:0]       bitn, bitn_nxt;
    logic [VW-1:0]       conv;
    logic                sample, clr_shift, done, sclk_nxt;
    logic [DATA_BITS-1:0] sh  [NUM_CH];
    logic [AW-1:0]       acc [NUM_CH];
    logic [AW-1:0]       sum [NUM_CH];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        bitn_nxt  = bitn;
        sample    = 1'b0;
        clr_shift = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (cont)       state_nxt = S_HOLD;
                else if (start) state_nxt = S_FRONT_PORCH;
            end
            S_HOLD: begin
                if (cnt == CW'(CLOCKS_BETWEEN_TRANSACTIONS - 1)) begin
                    state_nxt = S_FRONT_PORCH;
                    cnt_nxt   = '0;
                end
            end
            S_FRONT_PORCH: begin
                if (cnt == CW'(CLOCKS_BEFORE_DATA - 1)) begin
                    state_nxt = S_SHIFTING;
                    cnt_nxt   = '0;
                    bitn_nxt  = '0;
                    clr_shift = 1'b1;
                end
            end
            S_SHIFTING: begin
                sample = (cnt == CW'(HALF - 1));
                if (cnt == CW'(CLOCKS_PER_BIT - 1)) begin
                    cnt_nxt  = '0;
                    bitn_nxt = bitn + BW'(1);
                    if (bitn == BW'(DATA_BITS - 1)) begin
                        state_nxt = S_BACK_PORCH;
                        done      = 1'b1;
                    end
                end
            end
            S_BACK_PORCH: begin
                if (cnt == CW'(CLOCKS_AFTER_DATA - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = cont ? S_HOLD : S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // sclk is registered from the next-state decode: same waveform, no glitches.
    assign sclk_nxt = !((state_nxt == S_SHIFTING) && (cnt_nxt < CW'(HALF)));
    assign cs       = ~state[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            bitn  <= '0;
            sclk  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            bitn  <= bitn_nxt;
            sclk  <= sclk_nxt;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) sum[i] = acc[i] + AW'(sh[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sh[i]  <= '0;
                acc[i] <= '0;
            end
            conv <= '0;
            dout <= '0;
            drdy <= 1'b0;
        end else begin
            drdy <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr_shift)   sh[i] <= '0;
                else if (sample) sh[i] <= {sh[i][DATA_BITS-2:0], sdin[i]};
            end
            if (done) begin
                if (conv == CONV_LAST) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        dout[i*DATA_BITS +: DATA_BITS] <= DATA_BITS'(sum[i] >> AVG_LOG2);
                        acc[i] <= '0;
                    end
                    conv <= '0;
                    drdy <= 1'b1;
                end else begin
                    for (int i = 0; i < NUM_CH; i++) acc[i] <= sum[i];
                    conv <= conv + VW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_adc_spi_poller.sv
// Scoreboard bench: ADC models push expected words at cs fall, monitors pop on drdy.
// Instance a: defaults; instance b: 4ch x 12 bit, 4x averaging, short porches.
`timescale 1ns/1ps
module tb_adc_spi_poller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    logic        rst_a_n, cont_a, start_a, cs_a, sclk_a, drdy_a;
    logic [1:0]  sdin_a;
    logic [31:0] dout_a;
    logic        rst_b_n, cont_b, start_b, cs_b, sclk_b, drdy_b;
    logic [3:0]  sdin_b;
    logic [47:0] dout_b;

    adc_spi_poller dut_a (
        .clk(clk), .rst_n(rst_a_n), .cont(cont_a), .start(start_a), .sdin(sdin_a),
        .cs(cs_a), .sclk(sclk_a), .dout(dout_a), .drdy(drdy_a)
    );

    adc_spi_poller #(
        .NUM_CH(4), .DATA_BITS(12), .CLOCKS_PER_BIT(8), .CLOCKS_BEFORE_DATA(6),
        .CLOCKS_AFTER_DATA(10), .CLOCKS_BETWEEN_TRANSACTIONS(8), .AVG_LOG2(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_b_n), .cont(cont_b), .start(start_b), .sdin(sdin_b),
        .cs(cs_b), .sclk(sclk_b), .dout(dout_b), .drdy(drdy_b)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic expire(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // ADC models: {ch1,ch0} and {ch3,ch2,ch1,ch0}
    logic [31:0] tab_a [7] = '{32'h0123_0ABC, 32'h0123_0ABC, 32'hFFFF_0000, 32'h8001_7FFE,
                              32'h5A5A_A5A5, 32'h1111_2222, 32'h0123_0ABC};
    logic [47:0] tab_b [11] = '{48'hFFF_555_AAA_064, 48'hFFF_555_AAA_065, 48'hFFE_555_AAA_066,
                               48'hFFD_555_AAA_069, 48'h789_456_123_7FF, 48'h004_003_002_001,
                               48'hFFF_FFF_FFF_FFF, 48'h001_AAA_555_000, 48'h000_AAA_AAA_001,
                               48'h000_AAA_555_002, 48'h000_AAA_AAA_003};
    logic [31:0] cur_a = '0;
    logic [47:0] cur_b = '0;
    int ti_a = 0, bi_a = 0, ti_b = 0, bi_b = 0;
    logic [31:0] sb_a [$];
    logic [47:0] sb_b [$];

    always @(negedge cs_a) begin
        if (ti_a < 7) begin
            cur_a = tab_a[ti_a];
            sb_a.push_back(tab_a[ti_a]);
        end else cur_a = '0;
        ti_a++;
        bi_a = 0;
    end
    always @(posedge sclk_a) if (!cs_a) bi_a++;
    always @* for (int i = 0; i < 2; i++) sdin_a[i] = (bi_a < 16) ? cur_a[i*16 + 15 - bi_a] : 1'b0;

    always @(negedge cs_b) begin
        cur_b = (ti_b < 11) ? tab_b[ti_b] : '0;
        if (ti_b == 3)  sb_b.push_back(48'hFFE_555_AAA_066);
        if (ti_b == 10) sb_b.push_back(48'h000_AAA_7FF_001);
        ti_b++;
        bi_b = 0;
    end
    always @(posedge sclk_b) if (!cs_b) bi_b++;
    always @* for (int i = 0; i < 4; i++) sdin_b[i] = (bi_b < 12) ? cur_b[i*12 + 11 - bi_b] : 1'b0;

    // Monitors: cs window shape, drdy latency, scoreboard compare.
    logic cs_prev_a = 1'b1, sclk_prev_a = 1'b1, cs_prev_b = 1'b1, sclk_prev_b = 1'b1;
    int len_a, fall_a, lowc_a, csf_a, len_b, fall_b, lowc_b, csf_b;
    bit abort_a = 1'b0, abort_b = 1'b0;
    logic [31:0] e_a;
    logic [47:0] e_b;

    always @(negedge clk) begin
        if (!cs_a) begin
            if (cs_prev_a) begin len_a = 0; fall_a = 0; lowc_a = 0; csf_a = cyc; end
            len_a++;
            if (!sclk_a) lowc_a++;
            if (sclk_prev_a && !sclk_a) fall_a++;
        end else if (!cs_prev_a) begin
            if (!abort_a) begin
                check("a_cs_window", len_a, 880);
                check("a_sclk_pulses", fall_a, 16);
                check("a_sclk_low_cycles", lowc_a, 160);
            end
            abort_a = 1'b0;
        end
        if (drdy_a) begin
            check("a_drdy_latency", cyc - csf_a, 380);
            if (sb_a.size() == 0) expire("a_unexpected_drdy");
            else begin
                e_a = sb_a.pop_front();
                check("a_dout", dout_a, e_a);
            end
        end
        cs_prev_a = cs_a;
        sclk_prev_a = sclk_a;
    end

    always @(negedge clk) begin
        if (!cs_b) begin
            if (cs_prev_b) begin len_b = 0; fall_b = 0; lowc_b = 0; csf_b = cyc; end
            len_b++;
            if (!sclk_b) lowc_b++;
            if (sclk_prev_b && !sclk_b) fall_b++;
        end else if (!cs_prev_b) begin
            if (!abort_b) begin
                check("b_cs_window", len_b, 112);
                check("b_sclk_pulses", fall_b, 12);
                check("b_sclk_low_cycles", lowc_b, 48);
            end
            abort_b = 1'b0;
        end
        if (drdy_b) begin
            check("b_drdy_latency", cyc - csf_b, 102);
            if (sb_b.size() == 0) expire("b_unexpected_drdy");
            else begin
                e_b = sb_b.pop_front();
                check("b_dout", dout_b, e_b);
            end
        end
        cs_prev_b = cs_b;
        sclk_prev_b = sclk_b;
    end

    task automatic wait_cs_a(input logic lvl, input int lim, input string nm);
        int k = 0;
        while (cs_a !== lvl && k < lim) begin @(negedge clk); k++; end
        if (cs_a !== lvl) expire(nm);
    endtask

    task automatic wait_cs_b(input logic lvl, input int lim, input string nm);
        int k = 0;
        while (cs_b !== lvl && k < lim) begin @(negedge clk); k++; end
        if (cs_b !== lvl) expire(nm);
    endtask

    task automatic wait_drdy_a(output int c, input string nm);
        int k = 0;
        do begin @(negedge clk); k++; end while (!drdy_a && k < 3000);
        if (!drdy_a) expire(nm);
        c = cyc;
    endtask

    initial begin
        #2ms;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        cont_a = 1'b0; start_a = 1'b0; cont_b = 1'b0; start_b = 1'b0;
        #1;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("a_reset_cs", cs_a, 1'b1);
        check("a_reset_sclk", sclk_a, 1'b1);
        check("a_reset_drdy", drdy_a, 1'b0);
        check("a_reset_dout", dout_a, 32'h0);
        check("b_reset_cs", cs_b, 1'b1);
        check("b_reset_sclk", sclk_b, 1'b1);
        check("b_reset_dout", dout_b, 48'h0);
        fork
            begin : seq_a
                int n, t1, t2, lowc, sclc;
                cont_a = 1'b1;
                rst_a_n = 1'b1;
                n = 0;
                while (cs_a && n < 1000) begin @(posedge clk); n++; #1; end
                check("a_first_cs_fall", n, 401);
                wait_drdy_a(t1, "a_drdy_t0");
                wait_drdy_a(t2, "a_drdy_t1");
                check("a_drdy_period", t2 - t1, 1280);
                wait_drdy_a(t2, "a_drdy_t2");
                wait_cs_a(1'b1, 1000, "a_t2_end");
                repeat (100) @(negedge clk);
                cont_a = 1'b0;
                wait_cs_a(1'b0, 1000, "a_t3_start");
                wait_cs_a(1'b1, 1000, "a_t3_end");
                lowc = 0;
                repeat (2000) begin @(negedge clk); if (!cs_a) lowc++; end
                check("a_idle_after_cont_off", lowc, 0);
                start_a = 1'b1;
                @(negedge clk);
                start_a = 1'b0;
                check("a_oneshot_cs_fall", cs_a, 1'b0);
                repeat (100) @(negedge clk);
                start_a = 1'b1;
                @(negedge clk);
                start_a = 1'b0;
                wait_cs_a(1'b1, 1000, "a_oneshot_end");
                lowc = 0;
                sclc = 0;
                repeat (5000) begin
                    @(negedge clk);
                    if (!cs_a) lowc++;
                    if (!sclk_a) sclc++;
                end
                check("a_oneshot_idle_cs", lowc, 0);
                check("a_oneshot_idle_sclk", sclc, 0);
                cont_a = 1'b1;
                n = 0;
                while (cs_a && n < 1000) begin @(posedge clk); n++; #1; end
                check("a_resume_cs_fall", n, 401);
                repeat (205) @(negedge clk);
                check("a_bit7_sclk_low", sclk_a, 1'b0);
                #2;
                abort_a = 1'b1;
                sb_a.delete();
                rst_a_n = 1'b0;
                #1;
                check("a_async_rst_cs", cs_a, 1'b1);
                check("a_async_rst_sclk", sclk_a, 1'b1);
                check("a_async_rst_dout", dout_a, 32'h0);
                check("a_async_rst_drdy", drdy_a, 1'b0);
                @(negedge clk);
                rst_a_n = 1'b1;
                wait_drdy_a(t1, "a_drdy_after_reset");
                cont_a = 1'b0;
                wait_cs_a(1'b1, 1000, "a_final_end");
            end
            begin : seq_b
                int lowc;
                cont_b = 1'b1;
                rst_b_n = 1'b1;
                repeat (7) begin
                    wait_cs_b(1'b1, 300, "b_wait_high");
                    wait_cs_b(1'b0, 300, "b_wait_low");
                end
                repeat (20) @(negedge clk);
                #2;
                abort_b = 1'b1;
                rst_b_n = 1'b0;
                #1;
                check("b_async_rst_cs", cs_b, 1'b1);
                check("b_async_rst_sclk", sclk_b, 1'b1);
                check("b_async_rst_dout", dout_b, 48'h0);
                check("b_async_rst_drdy", drdy_b, 1'b0);
                @(negedge clk);
                rst_b_n = 1'b1;
                repeat (4) begin
                    wait_cs_b(1'b1, 300, "b_wait_high2");
                    wait_cs_b(1'b0, 300, "b_wait_low2");
                end
                cont_b = 1'b0;
                wait_cs_b(1'b1, 300, "b_final_end");
                lowc = 0;
                repeat (300) begin @(negedge clk); if (!cs_b) lowc++; end
                check("b_idle_after_cont_off", lowc, 0);
            end
        join
        check("a_scoreboard_empty", sb_a.size(), 0);
        check("b_scoreboard_empty", sb_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
